// File: rtl/switch_adder_pkg.sv
// switch_adder_pkg: shared width, mode encoding and SW field positions for switch_adder
package switch_adder_pkg;
    localparam int WIDTH_C  = 4;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    localparam int A_LSB    = 0;
    localparam int B_LSB    = 4;
    localparam int CI_BIT   = 8;
    localparam int MODE_BIT = 9;
    typedef logic [WIDTH_C-1:0] operand_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell (a, b, ci -> s, co)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/switch_adder.sv
// switch_adder: registered 4-bit ripple add/subtract from SW to LEDR, 2-cycle latency
//   CLOCK_50 in  clock; reset in sync active-high
//   SW   in  [3:0]=A [7:4]=B [8]=carry/borrow-in [9]=mode (0 add, 1 sub)
//   LEDR out [3:0]=result [4]=carry-out [5]=signed overflow [8:6]=0 [9]=mode
//   SWITCH_ADDER_OVF_EN: when defined, LEDR[5] carries the overflow flag; otherwise 0
module switch_adder
    import switch_adder_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);
    operand_t a_q, b_q, b_x, sum;
    logic ci_q, mode_q, sub, ovf;
    logic [WIDTH_C:0] c;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            ci_q   <= 1'b0;
            mode_q <= MODE_ADD;
        end else begin
            a_q    <= SW[A_LSB +: WIDTH_C];
            b_q    <= SW[B_LSB +: WIDTH_C];
            ci_q   <= SW[CI_BIT];
            mode_q <= SW[MODE_BIT];
        end
    end
    // Subtract reuses the adder: A + ~B + ~ci equals A - B - ci
    assign sub  = (mode_q == MODE_SUB);
    assign b_x  = b_q ^ {WIDTH_C{sub}};
    assign c[0] = ci_q ^ sub;
    for (genvar i = 0; i < WIDTH_C; i++) begin : g_fa
        full_adder u_fa (.a(a_q[i]), .b(b_x[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end
`ifdef SWITCH_ADDER_OVF_EN
    assign ovf = c[WIDTH_C-1] ^ c[WIDTH_C];
`else
    assign ovf = 1'b0;
`endif
    always_ff @(posedge CLOCK_50) begin
        if (reset) LEDR <= '0;
        else       LEDR <= {mode_q, 3'b000, ovf, c[WIDTH_C], sum};
    end
endmodule

// File: tb/tb_switch_adder.sv
// tb_switch_adder: randomized and directed checks of switch_adder against an arithmetic model
module tb_switch_adder;
    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] SW       = '0;
    logic [9:0] LEDR;
    int vectors = 0;
    int miscompares = 0;

    switch_adder dut (.CLOCK_50(CLOCK_50), .reset(reset), .SW(SW), .LEDR(LEDR));

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [9:0] model(input logic [9:0] sw);
        int a  = int'(sw[3:0]);
        int b  = int'(sw[7:4]);
        int ci = int'(sw[8]);
        logic m = sw[9];
        int sa = (a > 7) ? a - 16 : a;
        int sb = (b > 7) ? b - 16 : b;
        int r, sr;
        logic ov;
        if (!m) begin
            r  = a + b + ci;
            sr = sa + sb + ci;
        end else begin
            r  = a - b - ci + 16;
            sr = sa - sb - ci;
        end
`ifdef SWITCH_ADDER_OVF_EN
        ov = (sr < -8) || (sr > 7);
`else
        ov = 1'b0;
`endif
        return {m, 3'b000, ov, 5'(r)};
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SW = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (LEDR !== 10'h000) begin
                miscompares++;
                $display("FAIL reset_hold: LEDR=%h want 000", LEDR);
            end
        end
        reset = 1'b0;
        step();
        vectors++;
        if (LEDR !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_release_1: LEDR=%h want 000", LEDR);
        end
        step();
        vectors++;
        if (LEDR !== model(10'h3FF) || LEDR[9:6] !== 4'b1000 || LEDR[4:0] !== 5'h0F) begin
            miscompares++;
            $display("FAIL reset_release_2: LEDR=%h want %h", LEDR, model(10'h3FF));
        end
        SW = 10'h1FF;
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (LEDR !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_midflight: LEDR=%h want 000", LEDR);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (LEDR !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_discard: LEDR=%h want 000", LEDR);
        end
    endtask

    task automatic test_add();
        logic [9:0] vec [2] = '{{1'b0, 1'b0, 4'd8, 4'd9}, {1'b0, 1'b1, 4'd8, 4'd9}};
        logic [4:0] want [2] = '{5'b1_0001, 5'b1_0010};
        for (int i = 0; i < 2; i++) begin
            SW = vec[i];
            step();
            step();
            vectors++;
            if (LEDR[4:0] !== want[i] || LEDR[9] !== 1'b0 || LEDR !== model(vec[i])) begin
                miscompares++;
                $display("FAIL add_%0d: LEDR=%h want low=%b full=%h", i, LEDR, want[i], model(vec[i]));
            end
        end
    endtask

    task automatic test_sub();
        logic [9:0] vec [2] = '{{1'b1, 1'b0, 4'd3, 4'd5}, {1'b1, 1'b0, 4'd5, 4'd3}};
        logic [4:0] want [2] = '{5'b1_0010, 5'b0_1110};
        for (int i = 0; i < 2; i++) begin
            SW = vec[i];
            step();
            step();
            vectors++;
            if (LEDR[4:0] !== want[i] || LEDR[9] !== 1'b1 || LEDR !== model(vec[i])) begin
                miscompares++;
                $display("FAIL sub_%0d: LEDR=%h want low=%b full=%h", i, LEDR, want[i], model(vec[i]));
            end
        end
    endtask

    task automatic test_ovf();
        logic [9:0] vec [3] = '{{1'b0, 1'b0, 4'd1, 4'd7}, {1'b1, 1'b0, 4'd1, 4'd8}, {1'b0, 1'b0, 4'd2, 4'd3}};
        logic [4:0] want [3] = '{5'b0_1000, 5'b1_0111, 5'b0_0101};
`ifdef SWITCH_ADDER_OVF_EN
        logic ovw [3] = '{1'b1, 1'b1, 1'b0};
`else
        logic ovw [3] = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            SW = vec[i];
            step();
            step();
            vectors++;
            if (LEDR[4:0] !== want[i] || LEDR[5] !== ovw[i] || LEDR[8:6] !== 3'b000) begin
                miscompares++;
                $display("FAIL ovf_%0d: LEDR=%h want low=%b ovf=%b", i, LEDR, want[i], ovw[i]);
            end
        end
    endtask

    // LEDR after each edge must reflect the SW driven two edges earlier
    task automatic run_stream(input string name, input logic [9:0] hist []);
        int n = hist.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k >= 2) begin
                vectors++;
                if (LEDR !== model(hist[k-2])) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: SW=%h LEDR=%h want %h", name, k - 2, hist[k-2], LEDR, model(hist[k-2]));
                end
            end
            if (k < n) SW = hist[k];
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] hist [] = new[8];
        for (int i = 0; i < 8; i++) hist[i] = 10'($urandom);
        run_stream("back_to_back", hist);
    endtask

    task automatic test_sweep();
        logic [9:0] hist [] = new[1024];
        for (int i = 0; i < 1024; i++) hist[i] = 10'(i);
        run_stream("sweep", hist);
    endtask

    task automatic test_random();
        logic [9:0] hist [] = new[200];
        for (int i = 0; i < 200; i++) hist[i] = 10'($urandom);
        run_stream("random", hist);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
